alu_req_arbiter: RTL

//  Shares one registered 8-bit ALU slice (2-bit op select, 8-bit result + carry, same

---
 rtl/alu_req_arbiter_if.sv | 43 ++++
 rtl/alu_req_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter_if.sv
// Bundle of the request, ALU-lane and response channels of alu_req_arbiter.
// slave = arbiter side, master = requester/ALU/response-sink side.
interface alu_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int IDW     = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ*2-1:0] req_sel;

  logic [W-1:0]         alu_a;
  logic [W-1:0]         alu_b;
  logic [1:0]           alu_sel;
  logic [W-1:0]         alu_out;
  logic                 alu_carry;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [W-1:0]         resp_data;
  logic                 resp_carry;
  logic [IDW-1:0]       resp_id;

  modport slave (
    input  req_valid, req_a, req_b, req_sel,
    output req_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_carry,
    output resp_valid, resp_data, resp_carry, resp_id,
    input  resp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_sel,
    input  req_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_carry,
    input  resp_valid, resp_data, resp_carry, resp_id,
    output resp_ready
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered ALU lane between NUM_REQ requesters.
// Optional statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int ALU_LAT = 1,
  parameter int IDW     = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  alu_req_arbiter_if.slave  bus,
  output logic [15:0]       stat_grants,
  output logic [15:0]       stat_stalls,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a source holds its payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       id_q;
  logic [2:0]           exec_cnt_q;
  logic                 exec_last;
  logic [W-1:0]         alu_a_q;
  logic [W-1:0]         alu_b_q;
  logic [1:0]           alu_sel_q;
  logic [W-1:0]         resp_data_q;
  logic                 resp_carry_q;

  logic [NUM_REQ-1:0]   rot_valid;
  logic                 grant_found;
  logic [IDW-1:0]       grant_idx;
  logic                 accept;
  logic [NUM_REQ-1:0]   ready_vec;
  logic [W-1:0]         win_a;
  logic [W-1:0]         win_b;
  logic [1:0]           win_sel;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDW'(sum);
  endfunction

  // Rotate valids so bit k is requester (rr_ptr + k); lowest set bit wins.
  assign rot_valid = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_inc(rr_ptr_q, k);
      end
    end
  end

  // Ready is masked while reset is held so no requester sees an accept during reset.
  assign accept = (state_q == ST_IDLE) && grant_found && wb_rst_i;

  always_comb begin
    ready_vec = '0;
    win_a     = '0;
    win_b     = '0;
    win_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        ready_vec[i] = accept;
        win_a        = bus.req_a[i*W +: W];
        win_b        = bus.req_b[i*W +: W];
        win_sel      = bus.req_sel[i*2 +: 2];
      end
    end
  end

  assign exec_last = (exec_cnt_q == 3'(ALU_LAT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)         state_d = ST_EXEC;
      ST_EXEC: if (exec_last)      state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      rr_ptr_q     <= '0;
      id_q         <= '0;
      exec_cnt_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      resp_data_q  <= '0;
      resp_carry_q <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_q   <= win_a;
        alu_b_q   <= win_b;
        alu_sel_q <= win_sel;
        id_q      <= grant_idx;
        rr_ptr_q  <= wrap_inc(grant_idx, 1);
      end
      // Counts EXEC cycles; the ALU result is valid on the ALU_LAT-th one.
      if (state_q == ST_EXEC) begin
        exec_cnt_q <= exec_cnt_q + 3'd1;
      end else begin
        exec_cnt_q <= '0;
      end
      if ((state_q == ST_EXEC) && exec_last) begin
        resp_data_q  <= bus.alu_out;
        resp_carry_q <= bus.alu_carry;
      end
    end
  end

  assign bus.req_ready  = ready_vec;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_carry = resp_carry_q;
  assign bus.resp_id    = id_q;
  assign dbg_state      = state_q;

`ifdef ALU_ARB_STATS_EN
  logic stall;

  // A cycle with demand but no accept counts as contention.
  assign stall = (|bus.req_valid) && !accept;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (accept && (stat_grants != 16'hFFFF)) stat_grants <= stat_grants + 16'd1;
      if (stall && (stat_stalls != 16'hFFFF))  stat_stalls <= stat_stalls + 16'd1;
    end
  end
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif

endmodule
